// File: rtl/tetris_nios_button_pio.sv
// Avalon-MM button input PIO: sync, debounce, edge capture, maskable irq.
// Four-word map: DATA, IRQMASK, EDGECAP (W1C), RAW.
module tetris_nios_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_deb;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [31:0]      r_readdata;
  logic [CW-1:0]    r_cnt [WIDTH];

  logic             w_wr;
  logic [WIDTH-1:0] w_acc;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd;

  always_comb begin
    w_wr  = chipselect & ~write_n;
    w_acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_acc[i] = (r_sync2[i] != r_deb[i]) && (r_cnt[i] == CNT_LAST);
    end
    if (EDGE_TYPE == 0) begin
      w_set = w_acc & r_sync2;
    end else if (EDGE_TYPE == 1) begin
      w_set = w_acc & ~r_sync2;
    end else begin
      w_set = w_acc;
    end
    w_clr = '0;
    if (w_wr && address == 2'd2) begin
      w_clr = writedata[WIDTH-1:0];
    end
    w_rd = '0;
    unique case (address)
      2'd0: w_rd[WIDTH-1:0] = r_deb;
      2'd1: w_rd[WIDTH-1:0] = r_mask;
      2'd2: w_rd[WIDTH-1:0] = r_edge;
      2'd3: w_rd[WIDTH-1:0] = r_sync2;
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_deb      <= '0;
      r_mask     <= '0;
      r_edge     <= '0;
      r_readdata <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1    <= in_port;
      r_sync2    <= r_sync1;
      r_readdata <= w_rd;
      if (w_wr && address == 2'd1) begin
        r_mask <= writedata[WIDTH-1:0];
      end
      // set has priority over a same-cycle software clear
      r_edge <= (r_edge & ~w_clr) | w_set;
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (w_acc[i]) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge & r_mask);

endmodule

// File: tb/tb_tetris_nios_button_pio.sv
// Directed bench for tetris_nios_button_pio.
// WIDTH=4, DEBOUNCE_CYCLES=4, rising-edge capture.
module tb_tetris_nios_button_pio;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_vec;
  int n_err;

  tetris_nios_button_pio #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE(0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick(1);
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'h0;
    tick(2);
    chk("rst_rd0", readdata, 32'h0);
    chk("rst_irq0", 32'(irq), 32'h0);
    reset_n = 1'b1;

    // mid-debounce reset with inputs high
    in_port = 4'hF;
    address = 2'd3;
    tick(5);
    chk("raw_pre", readdata, 32'hF);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_rd", readdata, 32'h0);
    chk("arst_irq", 32'(irq), 32'h0);
    tick(2);
    chk("rst_hold", readdata, 32'h0);
    reset_n = 1'b1;
    address = 2'd0;
    tick(6);
    chk("rst_data_t5", readdata, 32'h0);
    tick(1);
    chk("rst_data_t6", readdata, 32'hF);
    rd(2'd2);
    chk("rst_edge", readdata, 32'hF);
    rd(2'd1);
    chk("rst_mask", readdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    wr(2'd2, 32'hF);
    rd(2'd2);
    chk("w1c_all", readdata, 32'h0);

    // falling transitions are not captured
    in_port = 4'h0;
    tick(8);
    rd(2'd0);
    chk("fall_data", readdata, 32'h0);
    rd(2'd2);
    chk("fall_edge", readdata, 32'h0);

    // bit 0 press, latency boundary
    address = 2'd0;
    in_port = 4'h1;
    tick(6);
    chk("deb_t5", readdata, 32'h0);
    tick(1);
    chk("deb_t6", readdata, 32'h1);
    rd(2'd2);
    chk("deb_edge", readdata, 32'h1);
    wr(2'd2, 32'h1);

    // 3-cycle glitch on bit 1
    in_port = 4'h3;
    tick(3);
    in_port = 4'h1;
    tick(10);
    rd(2'd0);
    chk("glitch_data", readdata, 32'h1);
    rd(2'd2);
    chk("glitch_edge", readdata, 32'h0);

    // masked interrupt on bit 1
    wr(2'd1, 32'h2);
    in_port = 4'h3;
    tick(5);
    chk("irq_t4", 32'(irq), 32'h0);
    tick(1);
    chk("irq_t5", 32'(irq), 32'h1);
    rd(2'd2);
    chk("irq_edge", readdata, 32'h2);
    wr(2'd2, 32'h2);
    chk("irq_clr", 32'(irq), 32'h0);
    rd(2'd2);
    chk("irq_edge_clr", readdata, 32'h0);

    // capture while masked, then unmask
    wr(2'd1, 32'h0);
    in_port = 4'h7;
    tick(10);
    chk("mask_irq0", 32'(irq), 32'h0);
    rd(2'd2);
    chk("mask_edge", readdata, 32'h4);
    wr(2'd1, 32'h4);
    chk("unmask_irq", 32'(irq), 32'h1);
    rd(2'd1);
    chk("mask_rd", readdata, 32'h4);
    wr(2'd2, 32'h4);
    chk("mask_clr_irq", 32'(irq), 32'h0);

    // clear lands on the bit-3 accept edge
    in_port = 4'hF;
    tick(5);
    wr(2'd2, 32'h8);
    rd(2'd2);
    chk("coll_edge", readdata, 32'h8);
    chk("coll_irq", 32'(irq), 32'h0);

    // release bit 0: raw first, debounced later, no capture
    address = 2'd3;
    in_port = 4'hE;
    tick(2);
    chk("raw_t1", readdata, 32'hF);
    tick(1);
    chk("raw_t2", readdata, 32'hE);
    address = 2'd0;
    tick(1);
    chk("rel_data_t3", readdata, 32'hF);
    tick(2);
    chk("rel_data_t5", readdata, 32'hF);
    tick(1);
    chk("rel_data_t6", readdata, 32'hE);
    rd(2'd2);
    chk("rel_edge", readdata, 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tetris_nios_button_pio.md
# tetris_nios_button_pio

Parametrised Avalon-MM input PIO for the Tetris Nios system, replacing the per-button 1-bit input ports with one multi-bit peripheral. Each input bit gets a two-flop synchroniser, a debounce filter, edge capture and a maskable interrupt. Software reads clean button levels, latched press events and raw levels over a four-word register map. The single `irq` output drives one Nios interrupt line.

## Interface
- `WIDTH`, 4: number of input bits, 1..32.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles needed to accept a new level, 1..2^20.
- `EDGE_TYPE`, 0: edge that sets edge capture. 0 = rising, 1 = falling, 2 = any.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 2: word address.
- `chipselect` in 1: slave select. Qualifies writes only.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `in_port` in WIDTH: asynchronous button inputs.
- `readdata` out 32: registered read data.
- `irq` out 1: level interrupt, active high.

## Operation
- **Register map**
  - 0 DATA (RO): debounced levels `deb`.
  - 1 IRQMASK (RW): `mask`.
  - 2 EDGECAP (RO, write-1-to-clear): `edge`.
  - 3 RAW (RO): synchronised, undebounced levels `sync2`.
  - Unused upper read bits are 0. Writes to addresses 0 and 3 are ignored.
- **Write strobe:** a write occurs on any edge where `chipselect`=1 and `write_n`=0.
  - Address 1: `mask` <= `writedata[WIDTH-1:0]`.
  - Address 2: `edge` bits whose `writedata` bit is 1 are cleared.
- **Read path:** every cycle, `readdata` <= the selected register, zero-extended. There is no chipselect or read gating.
- **Synchroniser:** `sync1` <= `in_port`; `sync2` <= `sync1`.
- **Debounce, per bit i, counter of ceil(log2(DEBOUNCE_CYCLES+1)) bits:**
  - If `sync2[i]`==`deb[i]`: `cnt[i]` <= 0.
  - Else if `cnt[i]`==DEBOUNCE_CYCLES-1: `deb[i]` <= `sync2[i]` and `cnt[i]` <= 0. This is the accept event.
  - Else: `cnt[i]` <= `cnt[i]`+1.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count and never changes `deb`.
- **Edge capture:** `edge[i]` is set on an accept event of the configured polarity.
  - Rising: new value 1. Falling: new value 0. Any: either.
  - `edge[i]` holds until cleared by software.
  - If a set and a clear hit the same cycle, set wins.
- **Interrupt:** `irq` = OR of (`edge` & `mask`), decoded combinationally from registers only, so it is glitch-free.
- **Reset (asynchronous):** `sync1`, `sync2`, `deb`, `cnt`, `mask`, `edge` and `readdata` all go to 0, and `irq` goes to 0.
  - Reset asserted mid-debounce discards the pending count.
  - After release, any input held at 1 is accepted as a rising edge after the normal latency.

## Timing
- Let t0 be the first rising edge at which `in_port[i]` shows a new stable value.
  - `sync2[i]` is new after edge t0+1.
  - `deb[i]` and `edge[i]` update at edge t0+1+DEBOUNCE_CYCLES.
  - `irq` rises in the same cycle as `edge[i]` when `mask[i]`=1.
  - DATA and EDGECAP are visible on `readdata` one edge later, at t0+2+DEBOUNCE_CYCLES, with address held.
- Read latency is 1 cycle: `address` presented at edge n gives `readdata` valid after edge n+1. No wait states.
- A register write takes effect at the write edge. A read of the same register on the next edge returns the new value.
- Clearing the only set, masked `edge` bit drops `irq` after the write edge.
- Mask changes affect `irq` immediately after the write edge. Already-captured edges are not lost when masked.

## Test plan
Bench configuration: WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=0.
- **Reset:** assert `reset_n`=0 mid-cycle with `in_port`=4'hF. Then: `readdata`=0, `irq`=0, all registers 0. Release and hold inputs; DATA reads 0xF and EDGECAP reads 0xF at t0+6.
- **Debounce:**
  - Set `in_port[0]` 0->1 and hold. `deb[0]` changes at t0+5. Address 0 returns 0x1 at t0+6.
  - A 3-cycle pulse on `in_port[1]` leaves DATA and EDGECAP at 0.
- **Interrupt:** write IRQMASK=0x2, then press bit 1. `irq` goes 1 with EDGECAP=0x2. Write 0x2 to address 2; `irq` is 0 the next cycle.
- **Masking:** with mask=0, pressing bit 2 sets EDGECAP=0x4 while `irq` stays 0. Writing mask=0x4 raises `irq` immediately.
- **Set/clear collision:** schedule a write-1-to-clear of bit 3 on the exact accept edge of a bit-3 rising edge. EDGECAP[3] remains 1.
- **RAW and falling edges:** release bit 0 (1->0). RAW shows 0 after 2 cycles while DATA still shows 1 until t0+6. No edge is captured for the falling transition.
